// File: rtl/al_accel_pkg.sv
`default_nettype none
// ---------------------------------------------------------------
// al_accel_pkg : shared types and constants for the ireg sequencer
// Rev 1.0
// ---------------------------------------------------------------
package al_accel_pkg;

  localparam int DW_DEF = 8;
  localparam int CW_DEF = 8;
  localparam int WIN_K  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/al_accel_ireg_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------
// al_accel_ireg_ctrl_if : column valid/ready handshake from the feeder
// Rev 1.0
// ---------------------------------------------------------------
interface al_accel_ireg_ctrl_if #(
  parameter int DW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_d0;
  logic [DW-1:0] in_d1;
  logic [DW-1:0] in_d2;

  modport master (output in_valid, output in_d0, output in_d1, output in_d2, input in_ready);
  modport slave  (input in_valid, input in_d0, input in_d1, input in_d2, output in_ready);
endinterface
`default_nettype wire

// File: rtl/al_accel_ireg_cnt.sv
`default_nettype none
// ---------------------------------------------------------------
// al_accel_ireg_cnt : column/strip position of the next column to accept
// Rev 1.0
// ---------------------------------------------------------------
module al_accel_ireg_cnt
  import al_accel_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          inc,
  input  logic          clr,
  input  logic [CW-1:0] cfg_width,
  input  logic [CW-1:0] cfg_strips,
  output logic [CW-1:0] col_idx,
  output logic [CW-1:0] strip_idx,
  output logic          last_col,
  output logic          last_all
);

  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] strip_q, strip_d;

  assign col_idx   = col_q;
  assign strip_idx = strip_q;
  assign last_col  = (col_q == cfg_width - CW'(1));
  assign last_all  = last_col && (strip_q == cfg_strips - CW'(1));

  always_comb begin
    col_d   = col_q;
    strip_d = strip_q;
    if (clr) begin
      col_d   = '0;
      strip_d = '0;
    end else if (inc) begin
      if (last_col) begin
        col_d   = '0;
        strip_d = strip_q + CW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col_q   <= '0;
      strip_q <= '0;
    end else begin
      col_q   <= col_d;
      strip_q <= strip_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/al_accel_ireg_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------
// al_accel_ireg_ctrl : feeds 3-pixel columns into the ireg, flags full 3x3 windows
// Rev 1.0
// ---------------------------------------------------------------
module al_accel_ireg_ctrl
  import al_accel_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [CW-1:0]        cfg_width,
  input  logic [CW-1:0]        cfg_strips,
  al_accel_ireg_ctrl_if.slave  up,
  input  logic                 pe_stall,
  output logic [DW-1:0]        ireg_di_0,
  output logic [DW-1:0]        ireg_di_1,
  output logic [DW-1:0]        ireg_di_2,
  output logic                 ireg_enb,
  output logic                 win_valid,
  output logic [CW-1:0]        col_idx,
  output logic [CW-1:0]        strip_idx,
  output logic                 busy,
  output logic                 done
);

  localparam logic [CW-1:0] MIN_W   = CW'(WIN_K);
  localparam logic [CW-1:0] WIN_COL = CW'(WIN_K - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] width_q, width_d;
  logic [CW-1:0] strips_q, strips_d;
  logic [DW-1:0] di0_q, di0_d, di1_q, di1_d, di2_q, di2_d;
  logic          enb_q, enb_d;
  logic          win_q, win_d;
  logic [CW-1:0] col_idx_q, col_idx_d;
  logic [CW-1:0] strip_idx_q, strip_idx_d;

  logic          cnt_inc, cnt_clr;
  logic [CW-1:0] cnt_col, cnt_strip;
  logic          cnt_last_col, cnt_last_all;
  logic          xfer;

  al_accel_ireg_cnt #(.CW(CW)) u_cnt (
    .clk        (clk),
    .resetn     (resetn),
    .inc        (cnt_inc),
    .clr        (cnt_clr),
    .cfg_width  (width_q),
    .cfg_strips (strips_q),
    .col_idx    (cnt_col),
    .strip_idx  (cnt_strip),
    .last_col   (cnt_last_col),
    .last_all   (cnt_last_all)
  );

  assign up.in_ready = (state_q == ST_LOAD) && !pe_stall;
  assign xfer        = up.in_valid && up.in_ready;

  always_comb begin
    state_d     = state_q;
    width_d     = width_q;
    strips_d    = strips_q;
    di0_d       = di0_q;
    di1_d       = di1_q;
    di2_d       = di2_q;
    enb_d       = 1'b0;
    // The window flag trails the enable by one cycle, so it follows the column just loaded.
    win_d       = enb_q && (col_idx_q >= WIN_COL);
    col_idx_d   = col_idx_q;
    strip_idx_d = strip_idx_q;
    cnt_inc     = 1'b0;
    cnt_clr     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          width_d  = cfg_width;
          strips_d = cfg_strips;
          cnt_clr  = 1'b1;
          if ((cfg_width < MIN_W) || (cfg_strips == '0)) state_d = ST_DONE;
          else                                          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (xfer) begin
          cnt_inc     = 1'b1;
          enb_d       = 1'b1;
          di0_d       = up.in_d0;
          di1_d       = up.in_d1;
          di2_d       = up.in_d2;
          col_idx_d   = cnt_col;
          strip_idx_d = cnt_strip;
          if (cnt_last_col && cnt_last_all) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      width_q     <= '0;
      strips_q    <= '0;
      di0_q       <= '0;
      di1_q       <= '0;
      di2_q       <= '0;
      enb_q       <= 1'b0;
      win_q       <= 1'b0;
      col_idx_q   <= '0;
      strip_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      width_q     <= width_d;
      strips_q    <= strips_d;
      di0_q       <= di0_d;
      di1_q       <= di1_d;
      di2_q       <= di2_d;
      enb_q       <= enb_d;
      win_q       <= win_d;
      col_idx_q   <= col_idx_d;
      strip_idx_q <= strip_idx_d;
    end
  end

  assign ireg_di_0 = di0_q;
  assign ireg_di_1 = di1_q;
  assign ireg_di_2 = di2_q;
  assign ireg_enb  = enb_q;
  assign win_valid = win_q;
  assign col_idx   = col_idx_q;
  assign strip_idx = strip_idx_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_al_accel_ireg_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------
// tb_al_accel_ireg_ctrl : directed self-checking bench for the ireg sequencer
// Rev 1.0
// ---------------------------------------------------------------
module tb_al_accel_ireg_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic [7:0] cfg_width, cfg_strips;
  logic       pe_stall;
  logic [7:0] ireg_di_0, ireg_di_1, ireg_di_2;
  logic       ireg_enb, win_valid, busy, done;
  logic [7:0] col_idx, strip_idx;

  al_accel_ireg_ctrl_if #(.DW(8)) up ();

  al_accel_ireg_ctrl #(.DW(8), .CW(8)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .cfg_width  (cfg_width),
    .cfg_strips (cfg_strips),
    .up         (up),
    .pe_stall   (pe_stall),
    .ireg_di_0  (ireg_di_0),
    .ireg_di_1  (ireg_di_1),
    .ireg_di_2  (ireg_di_2),
    .ireg_enb   (ireg_enb),
    .win_valid  (win_valid),
    .col_idx    (col_idx),
    .strip_idx  (strip_idx),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [7:0] d0, d1, d2, col, strip;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  logic mon_en = 1'b0;
  logic t_degen = 1'b0;
  int   t_width = 0;
  logic hs_prev, enb_prev;
  logic [7:0] enb_prev_col, m_col, m_strip;
  int   hs_cnt, enb_cnt, win_cnt, done_cnt, last_hs_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: enable one cycle after each handshake, window one cycle after
  // an enable whose column index is 2 or more, data/position from the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [7:0] enb_col;
      exp_t e;
      enb_col = 8'd0;
      check("enb", ireg_enb, hs_prev);
      check("win", win_valid, enb_prev && (enb_prev_col >= 8'd2));
      if (ireg_enb) begin
        enb_cnt++;
        if (q.size() == 0) check("sb_empty", 1, 0);
        else begin
          e = q.pop_front();
          check("di0", ireg_di_0, e.d0);
          check("di1", ireg_di_1, e.d1);
          check("di2", ireg_di_2, e.d2);
          check("col_idx", col_idx, e.col);
          check("strip_idx", strip_idx, e.strip);
          enb_col = e.col;
        end
      end
      if (win_valid) win_cnt++;
      if (done) begin
        done_cnt++;
        if (!t_degen) begin
          check("done_gap", cyc - last_hs_cyc, 2);
          check("done_win", win_valid, 1);
        end
      end
      enb_prev     = ireg_enb;
      enb_prev_col = enb_col;
      hs_prev      = up.in_valid && up.in_ready;
      if (hs_prev) begin
        hs_cnt++;
        last_hs_cyc = cyc;
        q.push_back('{up.in_d0, up.in_d1, up.in_d2, m_col, m_strip});
        if (int'(m_col) == t_width - 1) begin
          m_col   = 8'd0;
          m_strip = m_strip + 8'd1;
        end else begin
          m_col = m_col + 8'd1;
        end
      end
    end
  end

  task automatic clear_mon(input int w);
    hs_prev = 0; enb_prev = 0; enb_prev_col = 0;
    hs_cnt = 0; enb_cnt = 0; win_cnt = 0; done_cnt = 0; last_hs_cyc = 0;
    m_col = 0; m_strip = 0; t_width = w;
    q.delete();
  endtask

  task automatic do_start(input logic [7:0] w, input logic [7:0] s);
    cfg_width = w; cfg_strips = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input int n, input int base, input int stall_after,
                      input int stall_len, input int restart_at);
    int   sent = 0;
    int   cyc_n = 0;
    int   stall_left = 0;
    logic hs;
    while (sent < n && cyc_n < 200) begin
      up.in_d0 = 8'(base + 3 * sent);
      up.in_d1 = 8'(base + 3 * sent + 1);
      up.in_d2 = 8'(base + 3 * sent + 2);
      up.in_valid = 1'b1;
      @(negedge clk);
      hs = up.in_valid && up.in_ready;
      if (pe_stall) check("stall_rdy", up.in_ready, 0);
      @(posedge clk); #1;
      cyc_n++;
      start = 1'b0;
      if (hs) begin
        sent++;
        if (sent == restart_at) begin
          cfg_width = 8'd3; cfg_strips = 8'd1; start = 1'b1;
        end
        if (sent == stall_after) begin
          pe_stall = 1'b1; stall_left = stall_len;
        end
      end else if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) pe_stall = 1'b0;
      end
    end
    up.in_valid = 1'b0;
    check("feed_sent", sent, n);
  endtask

  task automatic run_job(input string tag, input int w, input int s, input int exp_win,
                         input int stall_after, input int stall_len, input int restart_at);
    clear_mon(w);
    t_degen = 1'b0;
    mon_en  = 1'b1;
    do_start(8'(w), 8'(s));
    check({tag, "_busy"}, busy, 1);
    feed(w * s, 16 * w + s, stall_after, stall_len, restart_at);
    for (int i = 0; i < 20 && done_cnt == 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b0;
    check({tag, "_hs"}, hs_cnt, w * s);
    check({tag, "_enb_cnt"}, enb_cnt, w * s);
    check({tag, "_win_cnt"}, win_cnt, exp_win);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_idle"}, busy, 0);
    check({tag, "_sb_left"}, q.size(), 0);
  endtask

  task automatic run_degen(input string tag, input logic [7:0] w, input logic [7:0] s);
    clear_mon(int'(w));
    t_degen = 1'b1;
    mon_en  = 1'b1;
    up.in_valid = 1'b1;
    check({tag, "_pre_busy"}, busy, 0);
    do_start(w, s);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_done"}, done, 1);
    check({tag, "_rdy"}, up.in_ready, 0);
    @(posedge clk); #1;
    check({tag, "_busy_off"}, busy, 0);
    check({tag, "_done_off"}, done, 0);
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b0;
    up.in_valid = 1'b0;
    check({tag, "_hs"}, hs_cnt, 0);
    check({tag, "_enb_cnt"}, enb_cnt, 0);
    check({tag, "_win_cnt"}, win_cnt, 0);
    check({tag, "_done_cnt"}, done_cnt, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn = 1'b0; start = 1'b0; cfg_width = '0; cfg_strips = '0; pe_stall = 1'b0;
    up.in_valid = 1'b0; up.in_d0 = '0; up.in_d1 = '0; up.in_d2 = '0;
    #1;
    check("rst_enb", ireg_enb, 0);
    check("rst_win", win_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_di0", ireg_di_0, 0);
    check("rst_col", col_idx, 0);
    check("rst_rdy", up.in_ready, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;

    run_job("w4s1", 4, 1, 2, 0, 0, 0);
    run_job("w3s2", 3, 2, 2, 0, 0, 0);
    run_job("stall", 5, 1, 3, 2, 3, 0);
    run_degen("w2", 8'd2, 8'd1);
    run_degen("s0", 8'd5, 8'd0);
    run_job("restart", 6, 1, 4, 0, 0, 2);

    // Abort a width-8 job after its third column, then rerun it from scratch.
    clear_mon(8);
    do_start(8'd8, 8'd1);
    feed(3, 7, 0, 0, 0);
    #2 resetn = 1'b0;
    #1;
    check("abort_enb", ireg_enb, 0);
    check("abort_win", win_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_di0", ireg_di_0, 0);
    check("abort_col", col_idx, 0);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;
    check("abort_idle_done", done, 0);
    run_job("after_rst", 8, 1, 6, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/al_accel_ireg_ctrl.md
Name: al_accel_ireg_ctrl

Overview:
Sequencer for the accelerator input register (al_accel_ireg). It accepts 3-pixel columns from an upstream feeder over a valid/ready handshake and forwards them to the ireg. It generates the single-cycle ireg enable, tracks column and strip position, and flags each cycle in which the ireg holds a complete 3x3 window for the PE array. It sits between the DMA/feeder and al_accel_ireg, under start/done control from the accelerator top.

Parameters:
DW, 8, pixel data width
CW, 8, width of the column and strip counters and config fields

Ports:
clk  in  1  system clock, all state on rising edge
resetn  in  1  asynchronous, active-low reset
start  in  1  single-cycle job start; sampled only in IDLE
cfg_width  in  CW  columns per strip; legal range 3..2^CW-1
cfg_strips  in  CW  number of 3-row strips; legal range 1..2^CW-1
in_valid  in  1  upstream column valid
in_ready  out  1  controller can accept a column
in_d0, in_d1, in_d2  in  DW each  upstream column pixels, rows 0..2
pe_stall  in  1  PE array cannot accept a new window
ireg_di_0, ireg_di_1, ireg_di_2  out  DW each  registered column data to the ireg
ireg_enb  out  1  ireg load enable, one cycle per accepted column
win_valid  out  1  ireg holds a full 3x3 window this cycle
col_idx  out  CW  0-based column index of the last accepted column
strip_idx  out  CW  0-based current strip
busy  out  1  job in progress
done  out  1  single-cycle job-complete pulse

Behaviour:
- Reset (resetn=0, asynchronous): all outputs 0, state IDLE, counters 0, latched config 0.
- States are IDLE, LOAD, FLUSH and DONE.
- IDLE:
  - On start, latch cfg_width and cfg_strips; busy goes to 1 on the next edge.
  - If cfg_width<3 or cfg_strips==0, go to DONE with no transfers. Otherwise go to LOAD.
- LOAD:
  - in_ready = !pe_stall (combinational); in_ready=0 in every other state.
  - A transfer happens when in_valid & in_ready are both high at a rising edge (edge k).
  - After edge k: ireg_di_* <= in_d*, ireg_enb=1 for exactly cycle k..k+1, col_idx and strip_idx updated to that column's position.
  - ireg captures the data at edge k+1.
  - win_valid is 1 for cycle k+1..k+2 iff the transferred column's col_idx>=2. Windows never span strips.
  - Column counter wraps from cfg_width-1 to 0 and increments the strip counter.
  - The transfer of col cfg_width-1 in strip cfg_strips-1 moves the FSM to FLUSH.
- FLUSH: one cycle. ireg_enb for the last column is high here. Go to DONE.
- DONE: one cycle. done=1 and win_valid=1 for the final window (coincident). Then go to IDLE; busy=0 from the edge leaving DONE.
- Outputs with no transfer:
  - With no transfer, ireg_enb=0 and ireg_di_* hold their last value.
  - pe_stall blocks only new transfers. Already-issued ireg_enb and win_valid pulses still complete.
- Window counts: exactly cfg_width-2 win_valid pulses per strip, cfg_strips*(cfg_width-2) per job.
- start while busy is ignored. Config inputs are ignored except in the IDLE+start cycle.
- in_valid while not in LOAD: no handshake, data ignored.
- Reset asserted mid-job aborts immediately: no done pulse, and state returns to IDLE.
- Counters are unsigned CW-bit. No overflow is possible within the legal config range.

Decomposition:
- Shared package al_accel_pkg:
  - FSM state enum (IDLE/LOAD/FLUSH/DONE, 2-bit)
  - DW and CW defaults
  - constant WIN_K=3, used for the minimum width and the col_idx>=WIN_K-1 window test
- One sub-module, al_accel_ireg_cnt: column/strip counter pair.
  - Inputs: inc, clr, cfg_width, cfg_strips.
  - Outputs: col_idx, strip_idx, last_col, last_all.
  - Instantiated once; the FSM and output registers stay in al_accel_ireg_ctrl.

Test Plan:
- cfg_width=4, cfg_strips=1, start, in_valid held high, pe_stall=0 -> 4 handshakes on consecutive edges, 4 ireg_enb pulses, ireg_di_* match the inputs one cycle later, win_valid pulses for col 2 and 3 only, done high exactly 2 cycles after the last handshake edge, coincident with the last win_valid.
- cfg_width=3, cfg_strips=2, continuous input -> 6 ireg_enb pulses, exactly 2 win_valid pulses (strip 0 col 2, strip 1 col 2), none at strip 1 col 0/1, strip_idx steps 0->1.
- cfg_width=5, cfg_strips=1, pe_stall=1 for 3 cycles after the 2nd handshake -> in_ready=0 and no ireg_enb during the stall, in_d held stable is accepted once after release, total 5 enb and 3 win_valid pulses.
- start with cfg_width=2 (repeat with cfg_strips=0) -> in_ready never high, no ireg_enb or win_valid, done pulses 1 cycle after start, busy high for exactly that cycle.
- Second start pulse during a cfg_width=6 job with a different config -> ignored, original job completes with 4 win_valid pulses.
- Reset asserted after the 3rd handshake of a cfg_width=8 job -> all outputs 0 immediately (asynchronous), no done pulse, and a new start after release runs a full job from col 0.
